// File: rtl/motion_correct_seq_if.sv
// Point stream, corrected-point stream and datapath drive/return bundle for motion_correct_seq.
// master = the sequencer block, slave = its environment (source, sink and combinational datapath).
interface motion_correct_seq_if #(
    parameter int WP = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [WP-1:0] in_px;
    logic [WP-1:0] in_py;
    logic [WP-1:0] in_pz;
    logic [WP-1:0] in_dt;

    logic [WP-1:0] dp_px;
    logic [WP-1:0] dp_py;
    logic [WP-1:0] dp_pz;
    logic [WP-1:0] dp_dt;
    logic [WP-1:0] dp_a_x;
    logic [WP-1:0] dp_v_prev;
    logic [WP-1:0] dp_v_next;
    logic [WP-1:0] dp_cx;
    logic [WP-1:0] dp_cy;
    logic [WP-1:0] dp_cz;

    logic          out_valid;
    logic          out_ready;
    logic [WP-1:0] out_cx;
    logic [WP-1:0] out_cy;
    logic [WP-1:0] out_cz;

    modport master (
        input  in_valid, in_px, in_py, in_pz, in_dt,
        output in_ready,
        output dp_px, dp_py, dp_pz, dp_dt, dp_a_x, dp_v_prev,
        input  dp_v_next, dp_cx, dp_cy, dp_cz,
        output out_valid, out_cx, out_cy, out_cz,
        input  out_ready
    );

    modport slave (
        output in_valid, in_px, in_py, in_pz, in_dt,
        input  in_ready,
        input  dp_px, dp_py, dp_pz, dp_dt, dp_a_x, dp_v_prev,
        output dp_v_next, dp_cx, dp_cy, dp_cz,
        input  out_valid, out_cx, out_cy, out_cz,
        output out_ready
    );
endinterface

// File: rtl/motion_correct_seq.sv
// Frame sequencer for an external combinational motion corrector: accepts points, drives the
// datapath for one evaluation cycle, presents the corrected point and carries velocity across the frame.
module motion_correct_seq #(
    parameter int WP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [WP-1:0]        i_a_x_cfg,
    input  logic [15:0]          i_n_points,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [15:0]          o_pt_count,
    motion_correct_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        EVAL,
        OUTPUT,
        DONE
    } state_t;

    state_t        r_state;
    logic [15:0]   r_target;
    logic [15:0]   r_pt_count;
    logic          r_done;
    logic          r_out_valid;
    logic [WP-1:0] r_out_cx;
    logic [WP-1:0] r_out_cy;
    logic [WP-1:0] r_out_cz;
    logic [WP-1:0] r_dp_px;
    logic [WP-1:0] r_dp_py;
    logic [WP-1:0] r_dp_pz;
    logic [WP-1:0] r_dp_dt;
    logic [WP-1:0] r_dp_a_x;
    logic [WP-1:0] r_dp_v_prev;

    // Abort outranks every state action; start is only looked at in IDLE, where abort is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_pt_count  <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cx    <= '0;
            r_out_cy    <= '0;
            r_out_cz    <= '0;
            r_dp_px     <= '0;
            r_dp_py     <= '0;
            r_dp_pz     <= '0;
            r_dp_dt     <= '0;
            r_dp_a_x    <= '0;
            r_dp_v_prev <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && i_abort) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_dp_a_x    <= i_a_x_cfg;
                            r_target    <= i_n_points;
                            r_dp_v_prev <= '0;
                            r_pt_count  <= '0;
                            r_state     <= (i_n_points == 16'd0) ? DONE : ACCEPT;
                        end
                    end
                    ACCEPT: begin
                        if (bus.in_valid) begin
                            r_dp_px <= bus.in_px;
                            r_dp_py <= bus.in_py;
                            r_dp_pz <= bus.in_pz;
                            r_dp_dt <= bus.in_dt;
                            r_state <= EVAL;
                        end
                    end
                    EVAL: begin
                        r_out_cx    <= bus.dp_cx;
                        r_out_cy    <= bus.dp_cy;
                        r_out_cz    <= bus.dp_cz;
                        r_dp_v_prev <= bus.dp_v_next;
                        r_pt_count  <= r_pt_count + 16'd1;
                        r_out_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end
                    OUTPUT: begin
                        if (bus.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= (r_pt_count == r_target) ? DONE : ACCEPT;
                        end
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (r_state == ACCEPT);
    assign bus.out_valid = r_out_valid;
    assign bus.out_cx    = r_out_cx;
    assign bus.out_cy    = r_out_cy;
    assign bus.out_cz    = r_out_cz;
    assign bus.dp_px     = r_dp_px;
    assign bus.dp_py     = r_dp_py;
    assign bus.dp_pz     = r_dp_pz;
    assign bus.dp_dt     = r_dp_dt;
    assign bus.dp_a_x    = r_dp_a_x;
    assign bus.dp_v_prev = r_dp_v_prev;

    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;
    assign o_pt_count = r_pt_count;

endmodule

// File: tb/tb_motion_correct_seq.sv
// Directed bench for motion_correct_seq with a simple stand-in datapath whose results are hand-computed.
module tb_motion_correct_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] aXCfg;
    logic [15:0] nPoints;
    logic        busy;
    logic        done;
    logic [15:0] ptCount;

    int checkCount = 0;
    int errorCount = 0;

    motion_correct_seq_if #(.WP(32)) bus ();

    motion_correct_seq #(.WP(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_a_x_cfg  (aXCfg),
        .i_n_points (nPoints),
        .o_busy     (busy),
        .o_done     (done),
        .o_pt_count (ptCount),
        .bus        (bus)
    );

    // Stand-in datapath: v_next = v_prev + a + dt, cx = px + v_next, cy = py + v_prev, cz = pz - dt.
    assign bus.dp_v_next = bus.dp_v_prev + bus.dp_a_x + bus.dp_dt;
    assign bus.dp_cx     = bus.dp_px + bus.dp_v_next;
    assign bus.dp_cy     = bus.dp_py + bus.dp_v_prev;
    assign bus.dp_cz     = bus.dp_pz - bus.dp_dt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Points and their results with a = 0x18000, dt = 0x10000, velocity starting at 0.
    logic [31:0] ptX [3] = '{32'h0000_0100, 32'h0000_1000, 32'h0000_0005};
    logic [31:0] ptY [3] = '{32'h0000_0200, 32'h0000_2000, 32'h0000_0006};
    logic [31:0] ptZ [3] = '{32'h0000_0300, 32'h0000_3000, 32'h0000_0007};
    logic [31:0] expV  [4] = '{32'h0000_0000, 32'h0002_8000, 32'h0005_0000, 32'h0007_8000};
    logic [31:0] expCx [3] = '{32'h0002_8100, 32'h0005_1000, 32'h0007_8005};
    logic [31:0] expCy [3] = '{32'h0000_0200, 32'h0002_A000, 32'h0005_0006};
    logic [31:0] expCz [3] = '{32'hFFFF_0300, 32'hFFFF_3000, 32'hFFFF_0007};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulses start from IDLE, then scrambles the config inputs to show they were sampled only once.
    task automatic applyStimulus(input logic [31:0] ax, input logic [15:0] n);
        start   = 1'b1;
        aXCfg   = ax;
        nPoints = n;
        step();
        start   = 1'b0;
        aXCfg   = 32'hDEAD_BEEF;
        nPoints = 16'hFFFF;
    endtask

    task automatic setPoint(input int k);
        bus.in_px = ptX[k];
        bus.in_py = ptY[k];
        bus.in_pz = ptZ[k];
        bus.in_dt = 32'h0001_0000;
    endtask

    // Runs one point from ACCEPT through its output transfer; needs in_valid=1 and out_ready=1.
    task automatic runPoint(input int k, input logic [15:0] cnt);
        setPoint(k);
        checkOutput("accept_ready", bus.in_ready, 1);
        step();
        checkOutput("eval_ready", bus.in_ready, 0);
        checkOutput("eval_valid", bus.out_valid, 0);
        checkOutput("eval_vprev", bus.dp_v_prev, expV[k]);
        checkOutput("eval_px", bus.dp_px, ptX[k]);
        step();
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("out_cx", bus.out_cx, expCx[k]);
        checkOutput("out_cy", bus.out_cy, expCy[k]);
        checkOutput("out_cz", bus.out_cz, expCz[k]);
        checkOutput("vprev_carry", bus.dp_v_prev, expV[k+1]);
        checkOutput("pt_count", ptCount, cnt);
        step();
        checkOutput("out_valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        aXCfg         = '0;
        nPoints       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        setPoint(0);
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_ready", bus.in_ready, 0);
        checkOutput("rst_count", ptCount, 0);
        checkOutput("rst_ax", bus.dp_a_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Three-point frame at full throughput.
        bus.in_valid = 1'b1;
        applyStimulus(32'h0001_8000, 16'd3);
        checkOutput("f1_ax", bus.dp_a_x, 32'h0001_8000);
        for (int k = 0; k < 3; k++) runPoint(k, 16'(k + 1));
        checkOutput("f1_done_early", done, 0);
        checkOutput("f1_busy_done", busy, 1);
        step();
        checkOutput("f1_done", done, 1);
        checkOutput("f1_idle", busy, 0);
        checkOutput("f1_count", ptCount, 3);
        step();
        checkOutput("f1_done_pulse", done, 0);

        // Empty frame: straight to DONE, done two edges after start.
        bus.in_valid = 1'b0;
        applyStimulus(32'h0001_8000, 16'd0);
        checkOutput("f0_ready", bus.in_ready, 0);
        checkOutput("f0_done_early", done, 0);
        checkOutput("f0_busy", busy, 1);
        step();
        checkOutput("f0_done", done, 1);
        checkOutput("f0_valid", bus.out_valid, 0);
        step();
        checkOutput("f0_done_pulse", done, 0);

        // Abort during EVAL of the second point of four.
        bus.in_valid = 1'b1;
        applyStimulus(32'h0001_8000, 16'd4);
        runPoint(0, 16'd1);
        setPoint(1);
        step();
        checkOutput("ab_in_eval", bus.in_ready, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("ab_busy", busy, 0);
        checkOutput("ab_valid", bus.out_valid, 0);
        checkOutput("ab_done", done, 0);
        checkOutput("ab_count", ptCount, 1);
        checkOutput("ab_ready", bus.in_ready, 0);
        step();
        checkOutput("ab_no_done", done, 0);

        // Output stall for five cycles; also the first point after the abort must see zero velocity.
        bus.out_ready = 1'b0;
        applyStimulus(32'h0001_0000, 16'd1);
        setPoint(0);
        step();
        checkOutput("st_vprev0", bus.dp_v_prev, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("st_valid", bus.out_valid, 1);
            checkOutput("st_cx", bus.out_cx, 32'h0002_0100);
            checkOutput("st_cy", bus.out_cy, 32'h0000_0200);
            checkOutput("st_cz", bus.out_cz, 32'hFFFF_0300);
            checkOutput("st_ready", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        checkOutput("st_drop", bus.out_valid, 0);
        step();
        checkOutput("st_done", done, 1);
        checkOutput("st_count", ptCount, 1);

        // Asynchronous reset while holding a point in OUTPUT.
        bus.out_ready = 1'b0;
        applyStimulus(32'h0001_8000, 16'd1);
        setPoint(0);
        step();
        step();
        checkOutput("rr_valid_pre", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rr_valid", bus.out_valid, 0);
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_cx", bus.out_cx, 0);
        checkOutput("rr_vprev", bus.dp_v_prev, 0);
        checkOutput("rr_ax", bus.dp_a_x, 0);
        checkOutput("rr_count", ptCount, 0);
        checkOutput("rr_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        applyStimulus(32'h0001_8000, 16'd1);
        runPoint(0, 16'd1);
        step();
        checkOutput("rr_frame_done", done, 1);

        // Second start inside ACCEPT with a different config must be ignored.
        bus.in_valid = 1'b0;
        applyStimulus(32'h0001_8000, 16'd2);
        start   = 1'b1;
        aXCfg   = 32'h0000_7777;
        nPoints = 16'd9;
        step();
        start = 1'b0;
        checkOutput("rs_ready", bus.in_ready, 1);
        checkOutput("rs_ax", bus.dp_a_x, 32'h0001_8000);
        bus.in_valid = 1'b1;
        runPoint(0, 16'd1);
        runPoint(1, 16'd2);
        checkOutput("rs_in_done", bus.in_ready, 0);
        step();
        checkOutput("rs_done", done, 1);
        checkOutput("rs_count", ptCount, 2);
        checkOutput("rs_ax_end", bus.dp_a_x, 32'h0001_8000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/motion_correct_seq.md
MOTION_CORRECT_SEQ -- requirements
Module: motion_correct_seq

Interface
REQ-001 Parameter WP, default 32: data width of every point, time, acceleration and velocity word (signed Q16.16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle pulse; begins a frame; honoured in IDLE only.
REQ-005 abort  in  1  synchronous frame abort; honoured in any state except IDLE.
REQ-006 a_x_cfg  in  WP  frame acceleration, sampled on accepted start.
REQ-007 n_points  in  16  frame point count, sampled on accepted start.
REQ-008 in_valid / in_ready  in / out  1 / 1  input point handshake.
REQ-009 in_px, in_py, in_pz, in_dt  in  WP each  input point and its time step.
REQ-010 dp_px, dp_py, dp_pz, dp_dt, dp_a_x, dp_v_prev  out  WP each  registered drive to the combinational motion-corrector datapath.
REQ-011 dp_v_next, dp_cx, dp_cy, dp_cz  in  WP each  datapath results.
REQ-012 out_valid / out_ready  out / in  1 / 1  corrected point handshake.
REQ-013 out_cx, out_cy, out_cz  out  WP each  registered corrected point.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at frame completion.
REQ-016 pt_count  out  16  points emitted in current or most recent frame.

Function
REQ-017 FSM states SHALL be IDLE, ACCEPT, EVAL, OUTPUT, DONE.
REQ-018 IDLE + start: latch a_x_cfg->dp_a_x, n_points->target; clear dp_v_prev and pt_count; go ACCEPT, or DONE if n_points==0.
REQ-019 start outside IDLE SHALL be ignored; a_x_cfg/n_points changes outside an accepted start SHALL not affect the frame.
REQ-020 in_ready SHALL be 1 only in ACCEPT (combinational from state); transfer = in_valid & in_ready at clk edge.
REQ-021 ACCEPT transfer: register in_px/py/pz/dt into dp_px/py/pz/dt; go EVAL.
REQ-022 EVAL lasts exactly one cycle: at its closing edge capture dp_cx/cy/cz->out_cx/cy/cz, dp_v_next->dp_v_prev, pt_count+1, out_valid<=1; go OUTPUT.
REQ-023 OUTPUT: out_valid and out_* held stable until out_valid & out_ready; on that edge out_valid<=0 and go DONE if pt_count==target, else ACCEPT.
REQ-024 DONE: done=1 for exactly one cycle; go IDLE.
REQ-025 Latency: input transfer edge to out_valid high = 2 clk edges; max throughput one point per 3 cycles with out_ready held 1.
REQ-026 dp_v_prev SHALL carry velocity across points of one frame only; first point of each frame SHALL see dp_v_prev=0.
REQ-027 dp_* outputs SHALL hold their last value outside EVAL; dp_a_x constant for the whole frame.
REQ-028 No arithmetic inside block beyond pt_count increment (16-bit unsigned, cannot exceed target, target max 65535).
REQ-029 abort (not IDLE): next edge go IDLE, out_valid<=0, done not pulsed, pt_count retains count emitted; abort wins over any simultaneous handshake.
REQ-030 start and abort in same IDLE cycle: start honoured, abort ignored.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid 0, done 0, in_ready 0, busy 0, pt_count 0, all dp_* and out_* 0, target 0.
REQ-032 Reset mid-frame SHALL discard the frame with no done pulse; first post-reset start SHALL behave as REQ-018.

Verification
REQ-033 start, n_points=3, a_x_cfg=0x00018000 (1.5), in_valid always 1, out_ready always 1 -> 3 out_valid pulses 3 cycles apart, dp_v_prev of point k == dp_v_next of point k-1, done one cycle after third output transfer, pt_count=3.
REQ-034 start, n_points=0 -> done pulses 2 cycles after start, no in_ready, no out_valid.
REQ-035 out_ready held 0 for 5 cycles in OUTPUT -> out_valid and out_cx/cy/cz unchanged, in_ready 0 throughout; resumes on out_ready=1.
REQ-036 abort asserted in EVAL of point 2 of 4 -> IDLE next cycle, out_valid 0, no done, pt_count=1; next frame's first dp_v_prev=0.
REQ-037 rst_n pulsed low asynchronously mid-OUTPUT -> all outputs 0 before next clk edge; start after release runs a clean frame.
REQ-038 start pulsed again in ACCEPT with different a_x_cfg -> ignored, dp_a_x unchanged for rest of frame.
